// File: rtl/fetch_seq.sv
// fetch_seq: fetch-stage sequencer.
//   Owns the program counter and drives a req/ack instruction-memory port.
//   Applies decode stalls and execute-stage redirects, and hands one
//   registered instruction plus its PC to decode. A single-entry hold buffer
//   catches a returning fetch while decode is stalled.
//
// Parameters:
//   WIDTH     address/PC width
//   RESET_PC  PC loaded on reset
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   stall                  decode not accepting; current instr is held
//   br_taken, br_target    redirect request and absolute target (bits [1:0] ignored)
//   imem_req, imem_addr    memory request and word-aligned address
//   imem_ack, imem_rdata   memory data valid and instruction word
//   instr, instr_pc        instruction to decode and its PC
//   instr_valid            instr/instr_pc valid
//   flush                  one-cycle squash pulse for decode/execute
//   fetch_cnt, flush_cnt   performance counters, only when FETCH_PERF_CNT_EN is defined
//
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_cnt (instructions taken
// by decode) and flush_cnt (flush pulses), both 32-bit wrapping counters.

module fetch_seq #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    output logic             flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(3);

    logic [2:0]       state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] drain_addr;
    logic [31:0]      hold_instr;
    logic [WIDTH-1:0] hold_pc;
    logic [WIDTH-1:0] br_pc;
    logic             xfer;
    logic             slot_free;

    assign br_pc     = br_target & ~LOW_MASK;
    assign xfer      = imem_req && imem_ack;
    assign slot_free = !instr_valid || !stall;

    // While draining, the abandoned address stays on the bus; pc already
    // holds the redirect target.
    always_comb begin
        imem_addr = pc;
        if (state == S_DRAIN) begin
            imem_addr = drain_addr;
        end
    end

    // imem_req is registered so a raised request can never be withdrawn
    // before its ack, even if stall rises in the meantime. The "fetch only
    // when the output slot can drain" decision is made when the request is
    // issued; a fetch that lands on a stalled slot goes to the hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC & ~LOW_MASK;
            drain_addr  <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            flush       <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (state == S_IDLE) begin
                // A redirect seen during the idle cycle takes effect on entry to FETCH.
                state    <= S_FETCH;
                imem_req <= 1'b1;
                if (br_taken) begin
                    pc    <= br_pc;
                    flush <= 1'b1;
                end
            end else if (br_taken) begin
                pc          <= br_pc;
                flush       <= 1'b1;
                instr_valid <= 1'b0;
                if (imem_req && !imem_ack) begin
                    state      <= S_DRAIN;
                    drain_addr <= imem_addr;
                end else begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
            end else begin
                case (state)
                    S_FETCH, S_WAIT: begin
                        if (xfer) begin
                            pc <= pc + PC_STEP;
                            if (slot_free) begin
                                instr       <= imem_rdata;
                                instr_pc    <= pc;
                                instr_valid <= 1'b1;
                                state       <= S_FETCH;
                                imem_req    <= !stall;
                            end else begin
                                hold_instr <= imem_rdata;
                                hold_pc    <= pc;
                                state      <= S_HOLD;
                                imem_req   <= 1'b0;
                            end
                        end else begin
                            if (instr_valid && !stall) begin
                                instr_valid <= 1'b0;
                            end
                            if (imem_req) begin
                                state <= S_WAIT;
                            end else begin
                                state    <= S_FETCH;
                                imem_req <= !(instr_valid && stall);
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            instr    <= hold_instr;
                            instr_pc <= hold_pc;
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (imem_ack) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (instr_valid && !stall) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: self-checking bench for fetch_seq (WIDTH=32, RESET_PC=0).
// Memory returns memf(addr) for every address. Directed scenarios cover
// reset, streaming, delayed ack, hold buffer, redirects and wrap; a random
// phase checks the delivered instruction stream against program order.

module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fetch_seq #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .flush      (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Inputs are applied at the falling edge; memory data follows imem_addr.
    task automatic set_in(input logic s, input logic b, input logic [31:0] t, input logic a);
        stall      = s;
        br_taken   = b;
        br_target  = t;
        imem_ack   = a;
        imem_rdata = memf(imem_addr);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the DUT in FETCH with a request for address 0 pending.
    task automatic do_reset;
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic acks(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(1'b1, 1'b1, 32'h40, 1'b1);
        tick;
        tick;
        total++;
        if ({imem_req, instr_valid, flush, instr, instr_pc} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL reset_outputs got req=%b v=%b fl=%b instr=%h pc=%h exp 0/0/0/0/0",
                     imem_req, instr_valid, flush, instr, instr_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if ({fetch_cnt, flush_cnt} !== 64'h0) begin
            bad++;
            $display("FAIL reset_counters got %0d/%0d exp 0/0", fetch_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_stream;
        rst = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        tick;
        total++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL stream_c1 got req=%b addr=%h v=%b exp 1/00000000/0", imem_req, imem_addr, instr_valid);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        tick;
        total++;
        if ({instr_valid, instr_pc, instr, imem_addr} !== {1'b1, 32'h0, memf(32'h0), 32'h4}) begin
            bad++;
            $display("FAIL stream_c2 got v=%b pc=%h instr=%h addr=%h exp 1/0/%h/4",
                     instr_valid, instr_pc, instr, imem_addr, memf(32'h0));
        end
        for (int i = 1; i <= 5; i++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            tick;
            total++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(4 * i), memf(32'(4 * i))}) begin
                bad++;
                $display("FAIL stream_seq got v=%b pc=%h exp pc=%h", instr_valid, instr_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_ack_delay;
        do_reset;
        acks(2);
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
                bad++;
                $display("FAIL ackdly_stable cyc=%0d got req=%b addr=%h exp 1/8", k, imem_req, imem_addr);
            end
            set_in(1'b0, 1'b0, 32'h0, k == 3);
            tick;
        end
        total++;
        if ({instr_valid, instr_pc, instr, imem_req, imem_addr} !== {1'b1, 32'h8, memf(32'h8), 1'b1, 32'hC}) begin
            bad++;
            $display("FAIL ackdly_deliver got v=%b pc=%h req=%b addr=%h exp 1/8/1/c",
                     instr_valid, instr_pc, imem_req, imem_addr);
        end
        acks(1);
        total++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'hC}) begin
            bad++;
            $display("FAIL ackdly_nodup got v=%b pc=%h exp 1/c", instr_valid, instr_pc);
        end
    endtask

    task automatic test_hold;
        do_reset;
        acks(5);
        total++;
        if ({instr_valid, instr_pc, imem_req, imem_addr} !== {1'b1, 32'h10, 1'b1, 32'h14}) begin
            bad++;
            $display("FAIL hold_setup got v=%b pc=%h req=%b addr=%h exp 1/10/1/14",
                     instr_valid, instr_pc, imem_req, imem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b1);
            tick;
            total++;
            if ({instr_valid, instr_pc, instr, imem_req} !== {1'b1, 32'h10, memf(32'h10), 1'b0}) begin
                bad++;
                $display("FAIL hold_stalled cyc=%0d got v=%b pc=%h req=%b exp 1/10/0", k, instr_valid, instr_pc, imem_req);
            end
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        tick;
        total++;
        if ({instr_valid, instr_pc, instr, imem_req, imem_addr} !== {1'b1, 32'h14, memf(32'h14), 1'b1, 32'h18}) begin
            bad++;
            $display("FAIL hold_release got v=%b pc=%h req=%b addr=%h exp 1/14/1/18",
                     instr_valid, instr_pc, imem_req, imem_addr);
        end
        acks(1);
        total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h18, memf(32'h18)}) begin
            bad++;
            $display("FAIL hold_next got v=%b pc=%h exp 1/18", instr_valid, instr_pc);
        end
    endtask

    task automatic test_redirect_wait;
        do_reset;
        acks(8);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        tick;
        total++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h20, 1'b0}) begin
            bad++;
            $display("FAIL brwait_setup got req=%b addr=%h v=%b exp 1/20/0", imem_req, imem_addr, instr_valid);
        end
        set_in(1'b0, 1'b1, 32'h103, 1'b0);
        tick;
        total++;
        if ({flush, instr_valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, 32'h20}) begin
            bad++;
            $display("FAIL brwait_flush got fl=%b v=%b req=%b addr=%h exp 1/0/1/20", flush, instr_valid, imem_req, imem_addr);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        tick;
        total++;
        if ({flush, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h20}) begin
            bad++;
            $display("FAIL brwait_drain got fl=%b req=%b addr=%h exp 0/1/20", flush, imem_req, imem_addr);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        tick;
        total++;
        if ({instr_valid, flush, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 32'h100}) begin
            bad++;
            $display("FAIL brwait_dropped got v=%b fl=%b req=%b addr=%h exp 0/0/1/100", instr_valid, flush, imem_req, imem_addr);
        end
        acks(1);
        total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, memf(32'h100)}) begin
            bad++;
            $display("FAIL brwait_target got v=%b pc=%h exp 1/100", instr_valid, instr_pc);
        end
    endtask

    task automatic test_redirect_ack;
        do_reset;
        acks(12);
        set_in(1'b0, 1'b1, 32'h200, 1'b1);
        tick;
        total++;
        if ({flush, instr_valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, 32'h200}) begin
            bad++;
            $display("FAIL brack_flush got fl=%b v=%b req=%b addr=%h exp 1/0/1/200", flush, instr_valid, imem_req, imem_addr);
        end
        acks(1);
        total++;
        if ({flush, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h200}) begin
            bad++;
            $display("FAIL brack_target got fl=%b v=%b pc=%h exp 0/1/200", flush, instr_valid, instr_pc);
        end
    endtask

    // Redirect while stalled, to the top word of the address space.
    task automatic test_wrap;
        do_reset;
        acks(1);
        set_in(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
        tick;
        total++;
        if ({flush, instr_valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC}) begin
            bad++;
            $display("FAIL wrap_redirect got fl=%b v=%b req=%b addr=%h exp 1/0/1/fffffffc", flush, instr_valid, imem_req, imem_addr);
        end
        acks(1);
        total++;
        if ({instr_valid, instr_pc, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            bad++;
            $display("FAIL wrap_top got v=%b pc=%h addr=%h exp 1/fffffffc/0", instr_valid, instr_pc, imem_addr);
        end
        acks(1);
        total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, memf(32'h0)}) begin
            bad++;
            $display("FAIL wrap_zero got v=%b pc=%h exp 1/0", instr_valid, instr_pc);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        acks(3);
        set_in(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        total++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'hC, 1'b1}) begin
            bad++;
            $display("FAIL rstmid_setup got req=%b addr=%h v=%b exp 1/c/1", imem_req, imem_addr, instr_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({imem_req, instr_valid, imem_addr, flush} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL rstmid_async got req=%b v=%b addr=%h fl=%b exp 0/0/0/0", imem_req, instr_valid, imem_addr, flush);
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if ({fetch_cnt, flush_cnt} !== 64'h0) begin
            bad++;
            $display("FAIL rstmid_counters got %0d/%0d exp 0/0", fetch_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        tick;
        total++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL rstmid_restart got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, instr_valid);
        end
        acks(1);
        total++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL rstmid_first got v=%b pc=%h exp 1/0", instr_valid, instr_pc);
        end
    endtask

    // Program-order model: decode must see exp_pc, exp_pc+4, ... restarting
    // at every redirect target, each with the word memory holds there.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic [31:0] prev_ipc;
        logic [31:0] t;
        logic        prev_req, prev_ack, prev_br, prev_valid, prev_stall;
        logic        s, b, a;
        int          nd, fc, fl;
        do_reset;
        exp_pc = 32'h0;
        nd = 0; fc = 0; fl = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_br = 1'b0;
        prev_valid = 1'b0; prev_stall = 1'b0;
        prev_addr = 32'h0; prev_ipc = 32'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            total++;
            if (flush !== prev_br) begin
                bad++;
                $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", cyc, flush, prev_br);
            end
            if (prev_req && !prev_ack) begin
                total++;
                if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin
                    bad++;
                    $display("FAIL rnd_req_stable cyc=%0d got req=%b addr=%h exp 1/%h", cyc, imem_req, imem_addr, prev_addr);
                end
            end
            if (prev_valid && prev_stall && !prev_br) begin
                total++;
                if ({instr_valid, instr_pc} !== {1'b1, prev_ipc}) begin
                    bad++;
                    $display("FAIL rnd_stall_hold cyc=%0d got v=%b pc=%h exp 1/%h", cyc, instr_valid, instr_pc, prev_ipc);
                end
            end
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 6);
            a = ($urandom_range(0, 99) < 60);
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | {27'h0, t[4:0]};
            set_in(s, b, t, a);
            if (instr_valid && !s) fc++;
            if (b) begin
                exp_pc = t & ~32'h3;
                fl++;
            end else if (instr_valid && !s) begin
                total++;
                if ({instr_pc, instr} !== {exp_pc, memf(exp_pc)}) begin
                    bad++;
                    $display("FAIL rnd_stream cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                             cyc, instr_pc, instr, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                nd++;
            end
            prev_req = imem_req; prev_ack = a; prev_addr = imem_addr; prev_br = b;
            prev_valid = instr_valid; prev_stall = s; prev_ipc = instr_pc;
            tick;
        end
        total++;
        if (nd < 200) begin
            bad++;
            $display("FAIL rnd_progress got deliveries=%0d exp>=200", nd);
        end
`ifdef FETCH_PERF_CNT_EN
        total++;
        if ({fetch_cnt, flush_cnt} !== {32'(fc), 32'(fl - int'(prev_br))}) begin
            bad++;
            $display("FAIL rnd_counters got %0d/%0d exp %0d/%0d", fetch_cnt, flush_cnt, fc, fl - int'(prev_br));
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        test_reset;
        test_stream;
        test_ack_delay;
        test_hold;
        test_redirect_wait;
        test_redirect_ack;
        test_wrap;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Fetch-stage sequencer for the pipelined core. Owns the program counter and drives a req/ack instruction-memory port. Applies hazard-unit stalls and execute-stage branch/jump redirects. Delivers a registered instruction plus its PC to decode, and buffers one in-flight instruction when decode is stalled.

Parameters:
WIDTH, 32, address/PC width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
stall  input  1  decode not accepting; hold current instr output
br_taken  input  1  redirect request from execute stage
br_target  input  WIDTH  absolute redirect target; bits [1:0] ignored, treated as 00
imem_req  output  1  instruction-memory request
imem_addr  output  WIDTH  request address, word aligned
imem_ack  input  1  memory data valid; transfer occurs when imem_req && imem_ack
imem_rdata  input  32  instruction word
instr  output  32  instruction to decode
instr_pc  output  WIDTH  PC of instr
instr_valid  output  1  instr/instr_pc valid
flush  output  1  one-cycle pulse: decode/execute must squash

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_pc=0, instr_valid=0, flush=0, hold buffer empty.
- States:
  - IDLE: one cycle after rst deasserts, then FETCH.
  - FETCH: imem_req = !(instr_valid && stall); imem_addr = pc.
  - WAIT: a request was raised but not acked. imem_req=1 and imem_addr stay stable until ack, regardless of stall.
  - HOLD: one instruction is buffered; imem_req=0.
  - DRAIN: a request is outstanding after a redirect. imem_req=1 with the old address until ack; the returned data is discarded.
- Transfer, output slot free (!instr_valid || !stall): instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=pc+4, next state FETCH. Latency: ack cycle to instr_valid is 1 cycle.
- Transfer, output slot busy: data and address go to the hold buffer; pc<=pc+4; next state HOLD.
- HOLD with stall=0: buffer moves to the output (instr_valid stays 1); next state FETCH.
- Request raised in FETCH without ack: next state WAIT.
- Consumption: when instr_valid && !stall and no new data is written, instr_valid<=0.
- PC arithmetic: pc+4 is modulo 2^WIDTH; 0xFFFFFFFC wraps to 0.
- Redirect (br_taken=1) has top priority in every state except IDLE, where it is latched and applied on entry to FETCH:
  - pc <= {br_target[WIDTH-1:2],2'b00}.
  - flush=1 in the next cycle only.
  - instr_valid<=0 and the hold buffer is emptied.
  - If a request is outstanding with no ack this cycle: next state DRAIN. Otherwise: next state FETCH.
  - Ack in the same cycle as br_taken: the data is discarded and pc is not incremented.
  - br_taken during DRAIN: pc is updated to the new target; stay in DRAIN.
- DRAIN on ack: next state FETCH; the data is dropped.
- Simultaneous stall and br_taken: br_taken wins; flush pulse is still emitted.
- rst mid-operation: all state returns to reset values immediately; any outstanding memory transaction is abandoned (memory is reset by the same rst).

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs fetch_cnt[31:0] and flush_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_cnt increments on each instruction delivered to decode (instr_valid && !stall).
  - flush_cnt increments on each flush pulse.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. rst 1->0, imem_ack tied 1, stall=0 -> cycle1 imem_addr=0; cycle2 instr_valid=1, instr_pc=0, imem_addr=4; subsequent instr_pc=4, 8, 12 every cycle.
2. ack delayed 3 cycles on addr 0x8 -> imem_req=1 and imem_addr=0x8 stable for 4 cycles; instr_pc=0x8 the cycle after ack; no duplicate fetch.
3. instr_valid=1 (pc 0x10), stall=1, ack for 0x14 arrives -> state HOLD, instr_pc stays 0x10, imem_req=0; stall->0 -> instr_pc=0x14 next cycle, then fetch of 0x18.
4. br_taken=1, br_target=0x103, during WAIT on 0x20 -> flush=1 for one cycle, instr_valid=0, DRAIN until ack (data dropped), next imem_addr=0x100.
5. br_taken with imem_ack in the same cycle (addr 0x30), target 0x200 -> no instr_pc=0x30 ever delivered, next imem_addr=0x200, flush pulse once.
6. rst asserted mid-WAIT -> same-cycle imem_req=0, instr_valid=0, pc=RESET_PC; after release, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, both counters read 0.
